ram_sdp_be: RTL and testbench



---
 rtl/ram_pkg.sv | 29 ++
 rtl/ram_sdp_be_array.sv | 32 +++
 rtl/ram_sdp_be.sv | 159 +++++++++++++++
 tb/tb_ram_sdp_be.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-enabled simple-dual-port RAM family.
package ram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Widest word byte_merge can handle; callers zero-extend and truncate.
  localparam int unsigned RAM_MAX_DW = 1024;
  localparam int unsigned RAM_MAX_BE = RAM_MAX_DW / 8;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } ram_state_e;

  function automatic logic [RAM_MAX_DW-1:0] byte_merge(
    input logic [RAM_MAX_DW-1:0] old_word,
    input logic [RAM_MAX_DW-1:0] new_word,
    input logic [RAM_MAX_BE-1:0] be
  );
    logic [RAM_MAX_DW-1:0] merged;
    merged = old_word;
    for (int unsigned i = 0; i < RAM_MAX_BE; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ram_sdp_be_array.sv
// Storage array only: byte-enabled write port and registered read port,
// kept separate so it can be replaced by a vendor memory macro.
module ram_sdp_be_array #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wbe,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;
  localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:RAM_DEPTH-1];

  // Read samples the array before this edge's write lands (read-first).
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < NUM_BYTES; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ram_sdp_be.sv
// Simple-dual-port RAM with byte enables, post-reset clear sweep,
// selectable read latency and read-during-write behaviour.
module ram_sdp_be
  import ram_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    ADDR_WIDTH   = 8,
  parameter int                    READ_LATENCY = 1,
  parameter int                    RDW_MODE     = 0,
  parameter int                    INIT_CLEAR   = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    ready
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH > int'(RAM_MAX_DW)) begin : g_bad_width
    $error("ram_sdp_be: DATA_WIDTH must be a multiple of 8 and at most %0d", RAM_MAX_DW);
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("ram_sdp_be: READ_LATENCY must be 1 or 2");
  end
  if (RDW_MODE != RDW_READ_FIRST && RDW_MODE != RDW_WRITE_FIRST) begin : g_bad_rdw
    $error("ram_sdp_be: RDW_MODE must be 0 or 1");
  end

  ram_state_e            state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  clearing;
  logic                  wr_fire;
  logic                  rd_fire;

  logic                    arr_we;
  logic [ADDR_WIDTH-1:0]   arr_waddr;
  logic [DATA_WIDTH-1:0]   arr_wdata;
  logic [NUM_BYTES-1:0]    arr_wbe;
  logic [DATA_WIDTH-1:0]   arr_rdata;

  logic                  s1_valid;
  logic                  s1_coll;
  logic [DATA_WIDTH-1:0] s1_wdata;
  logic [NUM_BYTES-1:0]  s1_wbe;
  logic [DATA_WIDTH-1:0] merged_word;
  logic [DATA_WIDTH-1:0] rd_word;

  assign ready    = (state == ST_READY) && rst_n;
  assign clearing = (state == ST_CLEAR) && rst_n;
  assign wr_fire  = ready && wr_en;
  assign rd_fire  = ready && rd_en;

  // The clear sweep borrows the write port; user writes are blocked until READY.
  always_comb begin
    arr_we    = clearing || wr_fire;
    arr_waddr = wr_addr;
    arr_wdata = wr_data;
    arr_wbe   = wr_be;
    if (clearing) begin
      arr_waddr = clr_cnt;
      arr_wdata = INIT_VALUE;
      arr_wbe   = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
      clr_cnt <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == '1) state <= ST_READY;
        end
        ST_READY: state <= ST_READY;
        default:  state <= ST_READY;
      endcase
    end
  end

  ram_sdp_be_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .wbe   (arr_wbe),
    .re    (rd_fire),
    .raddr (rd_addr),
    .rdata (arr_rdata)
  );

  // The array always returns the pre-write word; write-first is rebuilt here by
  // merging the colliding write (captured alongside the read) onto that word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_coll  <= 1'b0;
      s1_wdata <= '0;
      s1_wbe   <= '0;
    end else begin
      s1_valid <= rd_fire;
      s1_coll  <= rd_fire && wr_fire && (wr_addr == rd_addr);
      if (rd_fire) begin
        s1_wdata <= wr_data;
        s1_wbe   <= wr_be;
      end
    end
  end

  assign merged_word = DATA_WIDTH'(byte_merge(RAM_MAX_DW'(arr_rdata), RAM_MAX_DW'(s1_wdata),
                                              RAM_MAX_BE'(s1_wbe)));
  assign rd_word     = (RDW_MODE == RDW_WRITE_FIRST && s1_coll) ? merged_word : arr_rdata;

  if (READ_LATENCY == 1) begin : g_lat1
    logic [DATA_WIDTH-1:0] hold_q;

    // Array output is already registered; a shadow register gives the
    // reset value and hold-when-idle behaviour without adding a cycle.
    always_ff @(posedge clk) begin
      if (!rst_n)        hold_q <= '0;
      else if (s1_valid) hold_q <= rd_word;
    end

    always_comb begin
      rd_valid = s1_valid;
      rd_data  = s1_valid ? rd_word : hold_q;
    end
  end else begin : g_lat2
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
      end else begin
        out_valid_q <= s1_valid;
        if (s1_valid) out_data_q <= rd_word;
      end
    end

    assign rd_valid = out_valid_q;
    assign rd_data  = out_data_q;
  end

endmodule

// File: tb/tb_ram_sdp_be.sv
// Randomised self-checking bench for ram_sdp_be: a latency-1/read-first and a
// latency-2/write-first instance share stimulus and one array-based model.
module tb_ram_sdp_be;

  localparam int          DW     = 16;
  localparam int          AW     = 4;
  localparam int          DEPTH  = 1 << AW;
  localparam logic [15:0] INIT_V = 16'hA5A5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [1:0]    wr_be;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  logic [DW-1:0] rd_data_a, rd_data_b;
  logic          rd_valid_a, rd_valid_b;
  logic          ready_a, ready_b;

  always #5 clk = ~clk;

  ram_sdp_be #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .READ_LATENCY (1),
    .RDW_MODE     (0),
    .INIT_CLEAR   (1),
    .INIT_VALUE   (INIT_V)
  ) u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data_a),
    .rd_valid (rd_valid_a),
    .ready    (ready_a)
  );

  ram_sdp_be #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .READ_LATENCY (2),
    .RDW_MODE     (1),
    .INIT_CLEAR   (1),
    .INIT_VALUE   (INIT_V)
  ) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data_b),
    .rd_valid (rd_valid_b),
    .ready    (ready_b)
  );

  typedef struct {
    int          due;
    logic [15:0] data;
  } rd_exp_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [15:0] mdl_mem [DEPTH];
  bit          mdl_ready;
  int          mdl_cnt;
  rd_exp_t     q_a[$];
  rd_exp_t     q_b[$];
  logic [15:0] last_a, last_b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] lane_merge(input logic [15:0] old_w, input logic [15:0] new_w,
                                             input logic [1:0] be);
    int res;
    res = 0;
    for (int i = 0; i < 2; i++) begin
      if (((be >> i) & 1) != 0) res += ((int'(new_w) >> (8 * i)) & 255) << (8 * i);
      else                      res += ((int'(old_w) >> (8 * i)) & 255) << (8 * i);
    end
    return 16'(res);
  endfunction

  // Behaviour of one rising edge, from the inputs present at that edge.
  task automatic model_edge();
    logic [15:0] old_w, wf_w;
    cyc++;
    if (!rst_n) begin
      mdl_ready = 1'b0;
      mdl_cnt   = 0;
      q_a.delete();
      q_b.delete();
      last_a = '0;
      last_b = '0;
    end else if (!mdl_ready) begin
      mdl_mem[mdl_cnt] = INIT_V;
      mdl_cnt++;
      if (mdl_cnt == DEPTH) mdl_ready = 1'b1;
    end else begin
      if (rd_en) begin
        old_w = mdl_mem[rd_addr];
        wf_w  = (wr_en && wr_addr == rd_addr) ? lane_merge(old_w, wr_data, wr_be) : old_w;
        q_a.push_back('{due: cyc,     data: old_w});
        q_b.push_back('{due: cyc + 1, data: wf_w});
      end
      if (wr_en) mdl_mem[wr_addr] = lane_merge(mdl_mem[wr_addr], wr_data, wr_be);
    end
  endtask

  task automatic check_outputs();
    chk("ready_a", 32'(ready_a), 32'(mdl_ready && rst_n));
    chk("ready_b", 32'(ready_b), 32'(mdl_ready && rst_n));
    if (q_a.size() > 0 && q_a[0].due == cyc) begin
      chk("valid_a", 32'(rd_valid_a), 32'd1);
      chk("data_a", 32'(rd_data_a), 32'(q_a[0].data));
      last_a = q_a[0].data;
      void'(q_a.pop_front());
    end else begin
      chk("valid_a", 32'(rd_valid_a), 32'd0);
      chk("hold_a", 32'(rd_data_a), 32'(last_a));
    end
    if (q_b.size() > 0 && q_b[0].due == cyc) begin
      chk("valid_b", 32'(rd_valid_b), 32'd1);
      chk("data_b", 32'(rd_data_b), 32'(q_b[0].data));
      last_b = q_b[0].data;
      void'(q_b.pop_front());
    end else begin
      chk("valid_b", 32'(rd_valid_b), 32'd0);
      chk("hold_b", 32'(rd_data_b), 32'(last_b));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input logic we, input int wa, input logic [15:0] wd, input logic [1:0] be,
                       input logic re, input int ra);
    wr_en   = we;
    wr_addr = AW'(wa);
    wr_data = wd;
    wr_be   = be;
    rd_en   = re;
    rd_addr = AW'(ra);
  endtask

  task automatic idle();
    drive(1'b0, 0, 16'h0000, 2'b00, 1'b0, 0);
  endtask

  // Addresses biased towards 0..3 so same-address collisions happen often.
  task automatic drive_random();
    int wa, ra;
    wa = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, DEPTH - 1));
    ra = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, DEPTH - 1));
    drive(1'($urandom), wa, 16'($urandom), 2'($urandom), 1'($urandom), ra);
  endtask

  task automatic count_to_ready(input string tag, input bit random_traffic);
    int n;
    n = 0;
    do begin
      if (random_traffic) drive_random();
      else                idle();
      step();
      n++;
    end while (!ready_a && n < 40);
    chk(tag, 32'(n), 32'(DEPTH));
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (3) step();

    // Release reset: ready after exactly DEPTH edges, then every word holds INIT_V.
    rst_n = 1'b1;
    count_to_ready("rdy_lat", 1'b0);
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, 0, 16'h0000, 2'b00, 1'b1, a);
      step();
    end
    idle();
    repeat (3) step();

    // Byte enables: full write then low-lane-only overwrite.
    drive(1'b1, 3, 16'h1234, 2'b11, 1'b0, 0); step();
    drive(1'b1, 3, 16'hFFEE, 2'b01, 1'b0, 0); step();
    drive(1'b0, 0, 16'h0000, 2'b00, 1'b1, 3); step();
    idle(); repeat (3) step();

    // Collision: high-lane write and read of the same address in one cycle.
    drive(1'b1, 5, 16'h0000, 2'b11, 1'b0, 0); step();
    drive(1'b1, 5, 16'hBEEF, 2'b10, 1'b1, 5); step();
    drive(1'b0, 0, 16'h0000, 2'b00, 1'b1, 5); step();
    idle(); repeat (3) step();

    // Back-to-back pipelined reads.
    for (int a = 0; a < 4; a++) begin
      drive(1'b1, a, 16'(10 + a), 2'b11, 1'b0, 0);
      step();
    end
    for (int a = 0; a < 4; a++) begin
      drive(1'b0, 0, 16'h0000, 2'b00, 1'b1, a);
      step();
    end
    idle(); repeat (4) step();

    for (int i = 0; i < 400; i++) begin
      drive_random();
      step();
    end
    idle(); repeat (3) step();

    // Reset partway through a sweep while traffic keeps coming.
    rst_n = 1'b0;
    drive_random(); step();
    drive_random(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive_random();
      step();
    end
    rst_n = 1'b0;
    drive_random(); step();
    rst_n = 1'b1;
    count_to_ready("rdy_restart", 1'b1);
    idle(); repeat (2) step();
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, 0, 16'h0000, 2'b00, 1'b1, a);
      step();
    end
    idle(); repeat (3) step();

    // Reset right behind a read: the read must never come out.
    drive(1'b1, 2, 16'h5A5A, 2'b11, 1'b0, 0); step();
    drive(1'b0, 0, 16'h0000, 2'b00, 1'b1, 2); step();
    rst_n = 1'b0;
    idle();
    step();
    chk("flush_data_a", 32'(rd_data_a), 32'd0);
    step();
    chk("flush_valid_b", 32'(rd_valid_b), 32'd0);
    chk("flush_data_b", 32'(rd_data_b), 32'd0);
    rst_n = 1'b1;
    count_to_ready("rdy_after_flush", 1'b0);
    for (int i = 0; i < 100; i++) begin
      drive_random();
      step();
    end
    idle(); repeat (4) step();

    chk("leftover_a", 32'(q_a.size()), 32'd0);
    chk("leftover_b", 32'(q_b.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
